// File: rtl/flb_ctrl_pkg.sv
// flb_ctrl_pkg: shared types and constants for the frequency-lock band controller.
//   - flb_state_e : controller FSM states
//   - MidScale    : loop-filter midscale code
//   - BandRst     : band value loaded at reset and at the start of every acquisition
//   - SatLo/SatHi : loop-filter codes reported as saturated
//   - ResearchCnt : consecutive saturated TRACK ticks that restart acquisition (FLB_RESEARCH_EN)
package flb_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSearch,
        StSettle,
        StTrack
    } flb_state_e;

    localparam logic [15:0] MidScale    = 16'h8000;
    localparam logic [7:0]  BandRst     = 8'h80;
    localparam logic [15:0] SatLo       = 16'h0000;
    localparam logic [15:0] SatHi       = 16'hFFFF;
    localparam int unsigned ResearchCnt = 4;

endpackage

// File: rtl/flb_ctrl_ref_edge_sync.sv
// ref_edge_sync: two-flop synchronizer for the asynchronous reference clock followed by a
// rising-edge detector. tick_o is one clk_i cycle wide, two cycles after the sampled edge.
// Ports:
//   clk_i   - sampling clock
//   rst_ni  - synchronous active-low reset
//   async_i - asynchronous input (reference clock treated as data)
//   tick_o  - single-cycle pulse per rising edge of async_i
module ref_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic tick_o
);

    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign tick_o = sync2_q & ~prev_q;

endmodule

// File: rtl/flb_ctrl.sv
// flb_ctrl: coarse DCO band acquisition (binary search on the frequency comparator) followed
// by tracking with lock detection on the loop-filter output.
// Optional feature: define FLB_RESEARCH_EN to restart acquisition after ResearchCnt
// consecutive saturated TRACK ticks; otherwise saturation is only reported on dlf_sat.
// Ports:
//   nsh_clk, rst_n          - clock and synchronous active-low reset
//   ref_clk                 - asynchronous reference clock, sampled as data
//   start, abort            - acquisition request / forced return to idle (abort wins)
//   dco_fast                - comparator result, sampled on reference ticks
//   dlf_out                 - loop-filter word, unsigned around MidScale
//   band                    - coarse band select
//   mtrx_clk_lag/smpl_clk_lag - constant synchronizer lag codes
//   trk_en, upd_stb, locked, busy, dlf_sat - status outputs, all registered
module flb_ctrl
    import flb_ctrl_pkg::*;
#(
    parameter int unsigned       BAND_W     = 8,
    parameter int unsigned       DLF_W      = 16,
    parameter int unsigned       SETTLE_CYC = 16,
    parameter logic [DLF_W-1:0]  LOCK_WIN   = 16'h0400,
    parameter int unsigned       LOCK_CNT   = 8,
    parameter logic [1:0]        MTRX_LAG   = 2'b10,
    parameter logic [1:0]        SMPL_LAG   = 2'b01
) (
    input  logic              nsh_clk,
    input  logic              rst_n,
    input  logic              ref_clk,
    input  logic              start,
    input  logic              abort,
    input  logic              dco_fast,
    input  logic [DLF_W-1:0]  dlf_out,
    output logic [BAND_W-1:0] band,
    output logic [1:0]        mtrx_clk_lag,
    output logic [1:0]        smpl_clk_lag,
    output logic              trk_en,
    output logic              upd_stb,
    output logic              locked,
    output logic              busy,
    output logic              dlf_sat
);

    localparam int unsigned IdxW = (BAND_W > 1) ? $clog2(BAND_W) : 1;
    localparam int unsigned SetW = $clog2(SETTLE_CYC + 1);
    localparam int unsigned LckW = $clog2(LOCK_CNT + 1);

    localparam logic [IdxW-1:0]   IdxTop     = IdxW'(BAND_W - 1);
    localparam logic [SetW-1:0]   SettleLast = SetW'(SETTLE_CYC - 1);
    localparam logic [LckW-1:0]   LockMax    = LckW'(LOCK_CNT);
    // Only the MSB set: equals BandRst at the default width.
    localparam logic [BAND_W-1:0] BandInit   = (BAND_W == 8) ? BAND_W'(BandRst)
                                                             : {1'b1, {(BAND_W-1){1'b0}}};

    flb_state_e          state_q;
    logic [BAND_W-1:0]   band_q, band_dec;
    logic [IdxW-1:0]     bit_idx_q;
    logic [SetW-1:0]     settle_cnt_q;
    logic [LckW-1:0]     lock_cnt_q;
    logic                trk_en_q, upd_stb_q, locked_q, busy_q, dlf_sat_q;
    logic                ref_tick;
    logic signed [DLF_W:0] diff;
    logic [DLF_W:0]      mag;
    logic                in_win, is_sat;
`ifdef FLB_RESEARCH_EN
    logic [1:0]          sat_run_q;
`endif

    ref_edge_sync u_ref_sync (
        .clk_i   (nsh_clk),
        .rst_ni  (rst_n),
        .async_i (ref_clk),
        .tick_o  (ref_tick)
    );

    // Band after deciding the current bit: clear it if the DCO is fast, then trial-set the next.
    always_comb begin
        band_dec = band_q;
        if (dco_fast) begin
            band_dec[bit_idx_q] = 1'b0;
        end
        if (bit_idx_q != '0) begin
            band_dec[bit_idx_q - 1'b1] = 1'b1;
        end
    end

    // 17-bit signed distance from midscale and its magnitude.
    always_comb begin
        diff   = $signed({1'b0, dlf_out}) - $signed({1'b0, DLF_W'(MidScale)});
        mag    = diff[DLF_W] ? -diff : diff;
        in_win = (mag <= {1'b0, LOCK_WIN});
        is_sat = (dlf_out == DLF_W'(SatLo)) || (dlf_out == DLF_W'(SatHi));
    end

    always_ff @(posedge nsh_clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            band_q       <= BandInit;
            bit_idx_q    <= '0;
            settle_cnt_q <= '0;
            lock_cnt_q   <= '0;
            trk_en_q     <= 1'b0;
            upd_stb_q    <= 1'b0;
            locked_q     <= 1'b0;
            busy_q       <= 1'b0;
            dlf_sat_q    <= 1'b0;
`ifdef FLB_RESEARCH_EN
            sat_run_q    <= '0;
`endif
        end else if (abort) begin
            // Band is deliberately kept.
            state_q      <= StIdle;
            settle_cnt_q <= '0;
            lock_cnt_q   <= '0;
            trk_en_q     <= 1'b0;
            upd_stb_q    <= 1'b0;
            locked_q     <= 1'b0;
            busy_q       <= 1'b0;
            dlf_sat_q    <= 1'b0;
`ifdef FLB_RESEARCH_EN
            sat_run_q    <= '0;
`endif
        end else begin
            upd_stb_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q   <= StSearch;
                        band_q    <= BandInit;
                        bit_idx_q <= IdxTop;
                        busy_q    <= 1'b1;
                    end
                end
                StSearch: begin
                    if (ref_tick) begin
                        band_q <= band_dec;
                        if (bit_idx_q != '0) begin
                            bit_idx_q    <= bit_idx_q - 1'b1;
                            settle_cnt_q <= '0;
                            state_q      <= StSettle;
                        end else begin
                            state_q    <= StTrack;
                            trk_en_q   <= 1'b1;
                            lock_cnt_q <= '0;
`ifdef FLB_RESEARCH_EN
                            sat_run_q  <= '0;
`endif
                        end
                    end
                end
                StSettle: begin
                    if (settle_cnt_q == SettleLast) begin
                        state_q <= StSearch;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 1'b1;
                    end
                end
                StTrack: begin
                    if (ref_tick) begin
                        upd_stb_q <= 1'b1;
                        dlf_sat_q <= is_sat;
                        if (in_win) begin
                            if (lock_cnt_q != LockMax) begin
                                lock_cnt_q <= lock_cnt_q + 1'b1;
                            end
                            locked_q <= (lock_cnt_q == LockMax);
                        end else begin
                            lock_cnt_q <= '0;
                            locked_q   <= 1'b0;
                        end
`ifdef FLB_RESEARCH_EN
                        if (is_sat) begin
                            if (sat_run_q == 2'(ResearchCnt - 1)) begin
                                state_q    <= StSearch;
                                band_q     <= BandInit;
                                bit_idx_q  <= IdxTop;
                                trk_en_q   <= 1'b0;
                                locked_q   <= 1'b0;
                                lock_cnt_q <= '0;
                                sat_run_q  <= '0;
                            end else begin
                                sat_run_q <= sat_run_q + 1'b1;
                            end
                        end else begin
                            sat_run_q <= '0;
                        end
`endif
                    end else begin
                        // Lock follows the counter one cycle after it reaches its ceiling.
                        locked_q <= (lock_cnt_q == LockMax);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign band         = band_q;
    assign mtrx_clk_lag = MTRX_LAG;
    assign smpl_clk_lag = SMPL_LAG;
    assign trk_en       = trk_en_q;
    assign upd_stb      = upd_stb_q;
    assign locked       = locked_q;
    assign busy         = busy_q;
    assign dlf_sat      = dlf_sat_q;

endmodule

// File: tb/tb_flb_ctrl.sv
// tb_flb_ctrl: self-checking bench for flb_ctrl. Table-driven and random band acquisitions,
// lock/saturation tracking against a behavioural model, and abort/reset corner sequences.
module tb_flb_ctrl;

    logic        nsh_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ref_clk = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        dco_fast = 1'b0;
    logic [15:0] dlf_out = 16'h8000;
    logic [7:0]  band;
    logic [1:0]  mtrx_clk_lag, smpl_clk_lag;
    logic        trk_en, upd_stb, locked, busy, dlf_sat;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;

    flb_ctrl dut (
        .nsh_clk      (nsh_clk),
        .rst_n        (rst_n),
        .ref_clk      (ref_clk),
        .start        (start),
        .abort        (abort),
        .dco_fast     (dco_fast),
        .dlf_out      (dlf_out),
        .band         (band),
        .mtrx_clk_lag (mtrx_clk_lag),
        .smpl_clk_lag (smpl_clk_lag),
        .trk_en       (trk_en),
        .upd_stb      (upd_stb),
        .locked       (locked),
        .busy         (busy),
        .dlf_sat      (dlf_sat)
    );

    always #5 nsh_clk = ~nsh_clk;

    // Counts strobe cycles; a one-cycle strobe per reference edge adds exactly one.
    always @(posedge nsh_clk) if (upd_stb) upd_cnt <= upd_cnt + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " band"}, 32'(band), 32'h80);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " trk_en"}, 32'(trk_en), 0);
        chk({tag, " upd_stb"}, 32'(upd_stb), 0);
        chk({tag, " locked"}, 32'(locked), 0);
        chk({tag, " dlf_sat"}, 32'(dlf_sat), 0);
        chk({tag, " mtrx_lag"}, 32'(mtrx_clk_lag), 32'h2);
        chk({tag, " smpl_lag"}, 32'(smpl_clk_lag), 32'h1);
    endtask

    // One reference edge, spaced well beyond the settle window. Called and returns at a negedge.
    task automatic ref_pulse(input logic [15:0] dlf, input logic fast);
        dco_fast = fast;
        dlf_out  = dlf;
        ref_clk  = 1'b1;
        repeat (4) @(negedge nsh_clk);
        ref_clk = 1'b0;
        repeat (20) @(negedge nsh_clk);
    endtask

    // Abort to idle, start, then 8 decisions; fast[7] is the first decision.
    task automatic do_acq(input logic [7:0] fast, input string tag);
        abort = 1'b1;
        @(negedge nsh_clk);
        abort = 1'b0;
        start = 1'b1;
        @(negedge nsh_clk);
        start = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            ref_pulse(16'h8000, fast[k]);
            if (k == 1) chk({tag, " trk_en after 7 decisions"}, 32'(trk_en), 0);
        end
    endtask

    // Successive approximation: each decision keeps its trial bit unless the DCO was fast.
    function automatic logic [7:0] model_band(input logic [7:0] fast);
        int b = 0;
        for (int k = 7; k >= 0; k--) if (!fast[k]) b = b + (1 << k);
        return 8'(b);
    endfunction

    typedef struct {
        logic [7:0] fast;
        logic [7:0] exp_band;
    } acq_vec_t;

    initial begin
        acq_vec_t vecs[5];
        int consec;
        int sat_run;
        int u0;
        logic [7:0] rp;
        logic [15:0] v;
        bit in_win;
        bit sat;

        vecs[0] = '{8'hFF, 8'h00};
        vecs[1] = '{8'h55, 8'hAA};
        vecs[2] = '{8'h00, 8'hFF};
        vecs[3] = '{8'h7F, 8'h80};
        vecs[4] = '{8'hFE, 8'h01};

        repeat (3) @(negedge nsh_clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge nsh_clk);

        // Table-driven acquisitions.
        for (int i = 0; i < 5; i++) begin
            do_acq(vecs[i].fast, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d band", i), 32'(band), 32'(vecs[i].exp_band));
            chk($sformatf("vec%0d trk_en", i), 32'(trk_en), 1);
            chk($sformatf("vec%0d busy", i), 32'(busy), 1);
        end

        // Random acquisitions against the model.
        for (int i = 0; i < 5; i++) begin
            rp = 8'($urandom);
            do_acq(rp, $sformatf("rnd%0d", i));
            chk($sformatf("rnd%0d band fast=%0h", i, rp), 32'(band), 32'(model_band(rp)));
            chk($sformatf("rnd%0d trk_en", i), 32'(trk_en), 1);
        end

        // Lock: 8 in-window ticks, then one out-of-window tick.
        for (int i = 0; i < 8; i++) begin
            u0 = upd_cnt;
            ref_pulse(16'h8100, 1'b0);
            chk($sformatf("lock tick%0d upd_stb count", i), 32'(upd_cnt - u0), 1);
            if (i == 6) chk("locked after 7 ticks", 32'(locked), 0);
        end
        chk("locked after 8 ticks", 32'(locked), 1);
        ref_pulse(16'h9000, 1'b0);
        chk("locked cleared by 9000", 32'(locked), 0);
        chk("band held in track", 32'(band), 32'(model_band(rp)));

        // Random tracking against a counting model.
        consec  = 0;
        sat_run = 0;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(7))
                0: v = 16'h8400;
                1: v = 16'h7C00;
                2: v = 16'h8401;
                3: v = 16'h7BFF;
                4: v = 16'($urandom_range(16'h8400, 16'h7C00));
                5: v = 16'h0000;
                6: v = 16'hFFFF;
                default: v = 16'($urandom);
            endcase
            if ((v == 16'h0000 || v == 16'hFFFF) && sat_run == 3) v = 16'h8000;
            in_win  = ((int'(v) - 32768) <= 1024) && ((int'(v) - 32768) >= -1024);
            sat     = (v == 16'h0000) || (v == 16'hFFFF);
            consec  = in_win ? ((consec < 8) ? consec + 1 : 8) : 0;
            sat_run = sat ? sat_run + 1 : 0;
            u0 = upd_cnt;
            ref_pulse(v, 1'($urandom));
            chk($sformatf("trk%0d locked dlf=%0h", i, v), 32'(locked), 32'(consec >= 8));
            chk($sformatf("trk%0d dlf_sat dlf=%0h", i, v), 32'(dlf_sat), 32'(sat));
            chk($sformatf("trk%0d upd_stb count", i), 32'(upd_cnt - u0), 1);
        end

        // Abort in TRACK clears status but keeps band.
        do_acq(8'h00, "sat");
        for (int i = 0; i < 4; i++) begin
            ref_pulse(16'hFFFF, 1'b0);
            if (i == 2) chk("dlf_sat after 3 sat ticks", 32'(dlf_sat), 1);
        end
`ifdef FLB_RESEARCH_EN
        chk("research trk_en", 32'(trk_en), 0);
        chk("research busy", 32'(busy), 1);
        chk("research band", 32'(band), 32'h80);
        chk("research locked", 32'(locked), 0);
`else
        chk("sat hold trk_en", 32'(trk_en), 1);
        chk("sat hold dlf_sat", 32'(dlf_sat), 1);
        chk("sat hold band", 32'(band), 32'hFF);
        abort = 1'b1;
        @(negedge nsh_clk);
        abort = 1'b0;
        chk("abort track dlf_sat", 32'(dlf_sat), 0);
        chk("abort track trk_en", 32'(trk_en), 0);
        chk("abort track band", 32'(band), 32'hFF);
`endif

        // Abort during SETTLE with a simultaneous start.
        abort = 1'b1;
        @(negedge nsh_clk);
        abort = 1'b0;
        start = 1'b1;
        @(negedge nsh_clk);
        start    = 1'b0;
        dco_fast = 1'b0;
        ref_clk  = 1'b1;
        repeat (6) @(negedge nsh_clk);
        chk("settle busy", 32'(busy), 1);
        chk("settle band", 32'(band), 32'hC0);
        abort = 1'b1;
        start = 1'b1;
        @(negedge nsh_clk);
        abort   = 1'b0;
        start   = 1'b0;
        ref_clk = 1'b0;
        chk("abort settle busy", 32'(busy), 0);
        chk("abort settle band", 32'(band), 32'hC0);
        repeat (30) @(negedge nsh_clk);
        chk("abort+start stays idle", 32'(busy), 0);

        // Reset mid-SEARCH, then a clean acquisition and tracking.
        start = 1'b1;
        @(negedge nsh_clk);
        start = 1'b0;
        ref_pulse(16'h8000, 1'b1);
        ref_pulse(16'h8000, 1'b1);
        chk("pre-reset band", 32'(band), 32'h20);
        u0 = upd_cnt;
        rst_n   = 1'b0;
        ref_clk = 1'b1;
        @(negedge nsh_clk);
        check_reset_outputs("midreset");
        rst_n   = 1'b1;
        ref_clk = 1'b0;
        repeat (30) @(negedge nsh_clk);
        chk("no residual upd_stb", 32'(upd_cnt - u0), 0);
        chk("post-reset idle", 32'(busy), 0);
        do_acq(8'h00, "post");
        chk("post band", 32'(band), 32'hFF);
        for (int i = 0; i < 3; i++) begin
            u0 = upd_cnt;
            ref_pulse(16'h8000, 1'b0);
            chk($sformatf("post tick%0d upd_stb count", i), 32'(upd_cnt - u0), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flb_ctrl.md
FLB_CTRL -- requirements
Module: flb_ctrl

Interface
REQ-001 Parameter BAND_W, default 8: width of the DCO band word.
REQ-002 Parameter DLF_W, default 16: width of the loop-filter word.
REQ-003 Parameter SETTLE_CYC, default 16: nsh_clk cycles to wait after each band change.
REQ-004 Parameter LOCK_WIN, default 16'h0400: maximum allowed |dlf_out - midscale| while locked.
REQ-005 Parameter LOCK_CNT, default 8: number of consecutive in-window ref ticks needed to declare lock.
REQ-006 Parameters MTRX_LAG and SMPL_LAG, defaults 2'b10 and 2'b01: lag codes driven to the synchronizer.
REQ-007 nsh_clk  in  1  sole clock; all state updates on its rising edge.
REQ-008 rst_n  in  1  reset, synchronous and active-low.
REQ-009 ref_clk  in  1  reference clock, asynchronous to nsh_clk, treated as data.
REQ-010 start  in  1  single-cycle request to start band acquisition.
REQ-011 abort  in  1  forces return to IDLE.
REQ-012 dco_fast  in  1  frequency comparator result (1 = DCO above target); sampled only on ref_tick.
REQ-013 dlf_out  in  DLF_W  loop-filter output, unsigned with midscale 16'h8000.
REQ-014 band  out  BAND_W  coarse DCO band select.
REQ-015 mtrx_clk_lag / smpl_clk_lag  out  2 each  lag configuration for the synchronizer.
REQ-016 trk_en  out  1  high in TRACK only.
REQ-017 upd_stb  out  1  one-cycle pulse requesting a synchronizer update.
REQ-018 locked  out  1  lock indicator.
REQ-019 busy  out  1  high in every state other than IDLE.
REQ-020 dlf_sat  out  1  dlf_out equalled 16'h0000 or 16'hFFFF at the last ref_tick in TRACK.

Function
REQ-021 ref_clk SHALL pass through a 2-FF synchronizer and a rising-edge detector; the result is ref_tick, one nsh_clk cycle wide, with at most 3 cycles of latency.
REQ-022 The FSM SHALL have four states: IDLE, SEARCH, SETTLE and TRACK.
REQ-023 IDLE: on start, go to SEARCH with band = 8'h80 and bit index = BAND_W-1.
REQ-024 SEARCH: on ref_tick, evaluate the current bit.
- If dco_fast = 1, clear the current bit.
- If the bit index > 0, set the next lower bit, decrement the index and go to SETTLE.
- If the bit index = 0, go to TRACK.
REQ-025 SETTLE: count SETTLE_CYC cycles, then return to SEARCH; ref_ticks during SETTLE are ignored.
REQ-026 A full acquisition SHALL take exactly BAND_W decisions; band is stable from the TRACK entry cycle onward.
REQ-027 TRACK: upd_stb SHALL assert on the cycle after each ref_tick; band is held.
REQ-028 Lock detection is evaluated on each TRACK ref_tick, using the 17-bit signed difference dlf_out - 16'h8000.
- If |difference| <= LOCK_WIN, increment the lock counter, saturating at LOCK_CNT.
- Otherwise clear the counter and deassert locked.
REQ-029 locked SHALL assert on the cycle after the counter reaches LOCK_CNT.
REQ-030 abort from any state SHALL go to IDLE on the next edge.
- Clears trk_en, locked, upd_stb, dlf_sat and the lock counter.
- band retains its value.
REQ-031 start and abort in the same cycle: abort wins.
REQ-032 start outside IDLE SHALL be ignored.
REQ-033 mtrx_clk_lag = MTRX_LAG and smpl_clk_lag = SMPL_LAG at all times after reset.

Reset
REQ-034 With rst_n = 0 at a rising edge, all of the following SHALL take effect on that edge:
- state = IDLE;
- band = 8'h80;
- trk_en = upd_stb = locked = busy = dlf_sat = 0;
- counters and synchronizer flops = 0;
- lag outputs = their parameter values.
REQ-035 Reset asserted mid-acquisition or mid-track SHALL abandon the operation, with no residual upd_stb.

Configuration
REQ-036 With FLB_RESEARCH_EN defined: 4 consecutive TRACK ref_ticks with dlf_sat conditions SHALL return the FSM to SEARCH.
- band resets to 8'h80 and locked clears.
REQ-037 Without FLB_RESEARCH_EN: the FSM SHALL stay in TRACK and only dlf_sat is reported.

Structure
REQ-038 Package flb_ctrl_pkg SHALL hold:
- the state enum;
- the midscale constant 16'h8000;
- the band reset constant 8'h80;
- the saturation codes.
REQ-039 Sub-module ref_edge_sync SHALL implement the 2-FF synchronizer and edge detector (REQ-021).

Verification
REQ-040 Bench: dco_fast = 1 on all ticks. Required: band = 8'h00 and TRACK entered after 8 decisions.
REQ-041 Bench: dco_fast pattern 0,1,0,1,0,1,0,1. Required: band = 8'hAA and trk_en = 1.
REQ-042 Bench: in TRACK with dlf_out = 16'h8100 for 8 ticks. Required: locked = 1; then dlf_out = 16'h9000 gives locked = 0 on the next tick.
REQ-043 Bench: abort asserted during SETTLE. Required: IDLE on the next edge, busy = 0, band retained; a simultaneous start is ignored.
REQ-044 Bench: with FLB_RESEARCH_EN, dlf_out = 16'hFFFF for 4 ticks in TRACK. Required: SEARCH with band = 8'h80; without the macro, TRACK is held and dlf_sat = 1.
REQ-045 Bench: rst_n pulsed low mid-SEARCH. Required: all outputs at the REQ-034 values, and a single upd_stb per ref_clk edge in later tracking.
